// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port data-memory bus seen by dmem_arbiter.
// The slave view belongs to the arbiter; the master view is the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic [DATA_W-1:0] p0_rdata;
    logic              p0_ack;
    logic              p0_err;
    logic              p0_stall;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic [DATA_W-1:0] p1_rdata;
    logic              p1_ack;
    logic              p1_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memWrite;
    logic              mem_memRead;
    logic [DATA_W-1:0] mem_readData;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_rdata, p0_ack, p0_err, p0_stall,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_rdata, p1_ack, p1_err,
        output mem_address, mem_writeData, mem_memWrite, mem_memRead,
        input  mem_readData
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_rdata, p0_ack, p0_err, p0_stall,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_rdata, p1_ack, p1_err,
        input  mem_address, mem_writeData, mem_memWrite, mem_memRead,
        output mem_readData
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of a single-port data memory: one access per
// three cycles (IDLE -> ISSUE -> RESP), illegal addresses are acked with err and never strobed.
module dmem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_BYTES   = 256,
    parameter int ALIGN_CHECK = 1
) (
    input logic             clk,
    input logic             rst_n,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Highest legal word start address, one bit wider so addresses near 2^ADDR_W cannot wrap.
    localparam logic [ADDR_W:0] LAST_WORD_ADDR = (ADDR_W+1)'(MEM_BYTES - 4);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        ack_q, ack_d;
    logic [1:0]        rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];

    logic [1:0]        req_vec;
    logic [1:0]        elig;
    logic              grant_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    function automatic logic addr_illegal(input logic [ADDR_W-1:0] a);
        logic out_of_range;
        logic misaligned;
        out_of_range = ({1'b0, a} > LAST_WORD_ADDR);
        misaligned   = (ALIGN_CHECK != 0) && (a[1:0] != 2'b00);
        return out_of_range | misaligned;
    endfunction

    assign req_vec = {bus.p1_req, bus.p0_req};

    // A port whose ack is showing this cycle sits out one arbitration round.
    assign elig       = req_vec & ~ack_q;
    assign grant_port = (elig == 2'b11) ? ~last_grant_q : elig[1];

    assign sel_we    = grant_port ? bus.p1_we    : bus.p0_we;
    assign sel_addr  = grant_port ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = grant_port ? bus.p1_wdata : bus.p0_wdata;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ack_d        = 2'b00;
        rsp_err_d    = 2'b00;
        rdata_d      = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|elig) begin
                    port_d       = grant_port;
                    last_grant_d = grant_port;
                    we_d         = sel_we;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    err_d        = addr_illegal(sel_addr);
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                ack_d[port_q]     = 1'b1;
                rsp_err_d[port_q] = err_q;
                if (!we_q && !err_q) begin
                    rdata_d[port_q] = bus.mem_readData;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ack_q        <= 2'b00;
            rsp_err_q    <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            rsp_err_q    <= rsp_err_d;
            for (int i = 0; i < 2; i++) begin
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

    // Memory bus always shows the latched request; only the strobes are state-qualified.
    assign bus.mem_address   = addr_q;
    assign bus.mem_writeData = wdata_q;
    assign bus.mem_memWrite  = (state_q == ST_ISSUE) & we_q & ~err_q;
    assign bus.mem_memRead   = (state_q == ST_ISSUE) & ~we_q & ~err_q;

    assign bus.p0_rdata = rdata_q[0];
    assign bus.p0_ack   = ack_q[0];
    assign bus.p0_err   = rsp_err_q[0];
    assign bus.p0_stall = bus.p0_req & ~ack_q[0];

    assign bus.p1_rdata = rdata_q[1];
    assign bus.p1_ack   = ack_q[1];
    assign bus.p1_err   = rsp_err_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two request agents, a byte memory, and a
// transaction-timestamp reference model that predicts every output each cycle.
module tb_dmem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 256;
    localparam int NCYC      = 1500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES), .ALIGN_CHECK(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- requester agents ----------------
    logic        a_req   [2];
    logic        a_we    [2];
    logic [31:0] a_addr  [2];
    logic [31:0] a_wdata [2];
    bit          a_busy  [2];

    assign bus.p0_req   = a_req[0];
    assign bus.p0_we    = a_we[0];
    assign bus.p0_addr  = a_addr[0];
    assign bus.p0_wdata = a_wdata[0];
    assign bus.p1_req   = a_req[1];
    assign bus.p1_we    = a_we[1];
    assign bus.p1_addr  = a_addr[1];
    assign bus.p1_wdata = a_wdata[1];

    // ---------------- environment memory (big-endian, registered read) ----------------
    logic [7:0] env_mem [MEM_BYTES] = '{default: 8'h00};

    always @(posedge clk) begin
        if (bus.mem_memWrite) begin
            for (int k = 0; k < 4; k++) begin
                env_mem[8'(bus.mem_address[7:0] + 8'(k))] <= bus.mem_writeData[31-8*k -: 8];
            end
        end
        if (bus.mem_memRead) begin
            bus.mem_readData <= {env_mem[8'(bus.mem_address[7:0])],
                                 env_mem[8'(bus.mem_address[7:0] + 8'd1)],
                                 env_mem[8'(bus.mem_address[7:0] + 8'd2)],
                                 env_mem[8'(bus.mem_address[7:0] + 8'd3)]};
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  model_mem [MEM_BYTES] = '{default: 8'h00};
    int          edge_n;
    bit          busy;
    int          g_edge;
    int          g_port;
    bit          g_we, g_err;
    logic [31:0] g_addr, g_wdata, g_rdata;
    bit          last_grant;
    bit          granted   [2];
    bit          exp_ack   [2];
    bit          exp_err   [2];
    logic [31:0] exp_rdata [2];
    bit          exp_wr, exp_rd;
    int          txn_count;

    int checks;
    int errors;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Legal iff the whole word fits: addr+3 <= MEM_BYTES-1, and word aligned.
    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned last_byte;
        last_byte = longint'(a) + 64'd3;
        return (last_byte > longint'(MEM_BYTES - 1)) || (a % 4 != 0);
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 11))
            0, 1, 2, 3, 4, 5: a = 32'(4 * $urandom_range(0, 15));
            6:  a = 32'h0000_00FC;
            7:  a = 32'h0000_00FD;
            8:  a = 32'h0000_0012;
            9:  a = 32'hFFFF_FFFC;
            10: a = 32'h0000_0100;
            default: a = $urandom;
        endcase
        return a;
    endfunction

    task automatic model_reset();
        busy       = 1'b0;
        last_grant = 1'b1;
        exp_wr     = 1'b0;
        exp_rd     = 1'b0;
        for (int p = 0; p < 2; p++) begin
            exp_ack[p]   = 1'b0;
            exp_err[p]   = 1'b0;
            exp_rdata[p] = 32'h0;
            granted[p]   = 1'b0;
        end
    endtask

    task automatic agents_idle();
        for (int p = 0; p < 2; p++) begin
            a_req[p]   = 1'b0;
            a_busy[p]  = 1'b0;
            a_we[p]    = 1'b0;
            a_addr[p]  = 32'h0;
            a_wdata[p] = 32'h0;
        end
    endtask

    task automatic new_txn(input int p);
        a_req[p]   = 1'b1;
        a_busy[p]  = 1'b1;
        a_we[p]    = ($urandom_range(0, 1) == 1);
        a_addr[p]  = pick_addr();
        a_wdata[p] = $urandom;
    endtask

    // Called right after each active clock edge while out of reset.
    task automatic model_edge();
        bit ack_prev [2];
        bit e0, e1;
        int pick;
        ack_prev = exp_ack;
        exp_ack  = '{1'b0, 1'b0};
        exp_err  = '{1'b0, 1'b0};
        exp_wr   = 1'b0;
        exp_rd   = 1'b0;
        edge_n++;
        if (busy) begin
            if (edge_n == g_edge + 1 && !g_err) begin
                if (g_we) begin
                    for (int k = 0; k < 4; k++)
                        model_mem[g_addr[7:0] + 8'(k)] = g_wdata[31-8*k -: 8];
                end else begin
                    g_rdata = {model_mem[g_addr[7:0]], model_mem[g_addr[7:0] + 8'd1],
                               model_mem[g_addr[7:0] + 8'd2], model_mem[g_addr[7:0] + 8'd3]};
                end
            end
            if (edge_n == g_edge + 2) begin
                exp_ack[g_port] = 1'b1;
                exp_err[g_port] = g_err;
                if (!g_we && !g_err) exp_rdata[g_port] = g_rdata;
                busy = 1'b0;
                txn_count++;
                $display("txn %0d port %0d %s addr=%08h wdata=%08h rdata=%08h err=%0d",
                         txn_count, g_port, g_we ? "WR" : "RD", g_addr, g_wdata,
                         exp_rdata[g_port], g_err);
            end
        end else begin
            e0 = a_req[0] && !ack_prev[0];
            e1 = a_req[1] && !ack_prev[1];
            if (e0 || e1) begin
                if (e0 && e1) pick = last_grant ? 0 : 1;
                else          pick = e1 ? 1 : 0;
                last_grant   = (pick == 1);
                busy         = 1'b1;
                g_edge       = edge_n;
                g_port       = pick;
                g_we         = a_we[pick];
                g_addr       = a_addr[pick];
                g_wdata      = a_wdata[pick];
                g_err        = addr_bad(g_addr);
                exp_wr       = g_we && !g_err;
                exp_rd       = !g_we && !g_err;
                granted[pick] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("p0_ack",   32'(bus.p0_ack),   32'(exp_ack[0]));
        check_eq("p1_ack",   32'(bus.p1_ack),   32'(exp_ack[1]));
        check_eq("p0_err",   32'(bus.p0_err),   32'(exp_err[0]));
        check_eq("p1_err",   32'(bus.p1_err),   32'(exp_err[1]));
        check_eq("p0_rdata", bus.p0_rdata,      exp_rdata[0]);
        check_eq("p1_rdata", bus.p1_rdata,      exp_rdata[1]);
        check_eq("mem_wr",   32'(bus.mem_memWrite), 32'(exp_wr));
        check_eq("mem_rd",   32'(bus.mem_memRead),  32'(exp_rd));
        check_eq("p0_stall", 32'(bus.p0_stall), 32'(a_req[0] && !exp_ack[0]));
        if (exp_wr || exp_rd) check_eq("mem_addr", bus.mem_address, g_addr);
        if (exp_wr)           check_eq("mem_wdata", bus.mem_writeData, g_wdata);
    endtask

    task automatic agent_step(input int p);
        int r;
        if (exp_ack[p]) begin
            a_busy[p]  = 1'b0;
            granted[p] = 1'b0;
            if (a_req[p] && $urandom_range(0, 1) == 1) new_txn(p);
            else a_req[p] = 1'b0;
        end else if (!a_busy[p]) begin
            if ($urandom_range(0, 2) == 0) new_txn(p);
        end else if (granted[p]) begin
            // Requester misbehaviour after grant must not disturb the transaction.
            r = $urandom_range(0, 7);
            if (r == 0) begin
                a_req[p] = 1'b0;
            end else if (r == 1) begin
                a_we[p]    = ~a_we[p];
                a_addr[p]  = pick_addr();
                a_wdata[p] = $urandom;
            end
        end
    endtask

    initial begin
        int rst_left;
        checks    = 0;
        errors    = 0;
        edge_n    = 0;
        txn_count = 0;
        rst_left  = 0;
        bus.mem_readData = 32'h0;
        agents_idle();
        model_reset();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                rst_n = 1'b1;
            end else if (rst_n && cyc > 20 && $urandom_range(0, 119) == 0) begin
                rst_n    = 1'b0;
                rst_left = $urandom_range(0, 1);
                model_reset();
                agents_idle();
            end else if (!rst_n && cyc > 2) begin
                if (rst_left == 0) rst_n = 1'b1;
                else rst_left--;
            end
            #1;
            check_outputs();
            if (rst_n) begin
                agent_step(0);
                agent_step(1);
            end
            @(posedge clk);
            if (rst_n) model_edge();
        end
        if (txn_count < 50) begin
            check_eq("txn_count_min", 32'(txn_count), 32'(50));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
